channel_reduce_param: RTL
=========================

Name: channel_reduce_param

Overview:
Parameterised, restartable successor to the fixed 4-element channel sum reducer. It pops COUNT words from an input channel and folds them with a run-time-selected operator (sum, max, min, xor). It pushes one result word to an output channel, then either restarts (continuous mode) or halts with valid held high (one-shot mode). It sits between two channel FIFOs in HLS-generated datapaths.

Parameters:
WIDTH, 32, data width of both channels and the accumulator.
COUNT, 4, elements per reduction; legal range 1 to 65535.
CONTINUOUS, 1, 1 = restart after each result; 0 = halt after the first result.

Ports:
clk  in  1  clock
rst  in  1  reset
op  in  2  operator: 0 = sum (wrapping), 1 = unsigned max, 2 = unsigned min, 3 = xor
in_in_data  out  WIDTH  unused write data; driven 0
in_read_valid  out  1  pop strobe to the input channel
in_rst  out  1  channel reset; driven 0
in_write_valid  out  1  unused; driven 0
in_out_data  in  WIDTH  head word of the input channel (first-word-fall-through)
in_read_ready  in  1  input channel non-empty
in_write_ready  in  1  unused
out_in_data  out  WIDTH  result word
out_read_valid  out  1  unused; driven 0
out_rst  out  1  channel reset; driven 0
out_write_valid  out  1  push strobe to the output channel
out_out_data  in  WIDTH  unused
out_read_ready  in  1  unused
out_write_ready  in  1  output channel not full
valid  out  1  result-complete indication
overflow  out  1  sum-mode carry-out flag for the current/last result

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk.
- Reset values: state=ACC, cnt=0, acc=0, op_q=0, overflow=0.
- Reset values of outputs: valid=0, in_read_valid=0, out_write_valid=0, out_in_data=0.
- All unused outputs are tied to 0 at all times.
- States: ACC, WRITE, DONE, HALT.
- ACC state:
  - in_read_valid = in_read_ready (combinational); a pop and its data transfer occur in the same cycle.
  - On a pop with cnt==0: acc <= in_out_data, op_q <= op, overflow <= 0.
  - On a pop with cnt>0: acc <= f(op_q, acc, in_out_data).
  - On every pop: cnt <= cnt+1.
  - When the COUNT-th element is popped, the next state is WRITE.
  - With no pop, everything holds.
- op is sampled only with the first element. Changes to op mid-reduction are ignored.
- Sum: acc+data truncated to WIDTH. Carry-out sets overflow (sticky until the next reduction starts).
- Max/min are unsigned compares; on a tie, acc is kept.
- WRITE state:
  - out_in_data = acc.
  - out_write_valid = out_write_ready (combinational).
  - When out_write_valid is high, go to DONE.
  - in_read_valid = 0 while stalled; back-pressure never drops data.
- DONE state: valid=1 for exactly one cycle; cnt <= 0. Next state is ACC if CONTINUOUS=1, else HALT.
- HALT state: valid=1 and out_in_data=acc held; no pops or pushes until rst.
- Outside DONE/HALT, valid=0. out_in_data = acc in every state except reset.
- Latency: with both channels always ready, the result is pushed COUNT cycles after the first pop. Continuous throughput is one result per COUNT+2 cycles.
- COUNT=1: the single element passes through unchanged; overflow=0.
- Reset mid-reduction: the partial accumulation is discarded; no pop or push occurs in a cycle where rst=1. The first pop after reset starts a fresh reduction.
- Counter width: $clog2(COUNT+1) bits.

Test Plan:
- Sum, COUNT=4, inputs 1,2,3,4, channels always ready -> one push of 10 at cycle 4 after the first pop; valid pulses 1 cycle; overflow=0.
- Same stream with in_read_ready gaps (ready low 3 cycles between the 2nd and 3rd words) -> no pops during gaps; result is still 10; exactly 4 pops.
- op=0, inputs 0xFFFFFFFF,1,0,0 -> result 0x00000000, overflow=1. Next reduction 1,1,1,1 -> result 4, overflow=0.
- op=1 then op=2 on inputs 5,0xFFFFFFFF,7,5 -> max 0xFFFFFFFF, min 5. Toggling op mid-stream -> no effect on the result.
- out_write_ready low 5 cycles in WRITE -> out_write_valid=0, in_read_valid=0, out_in_data stable; push occurs on the first ready cycle.
- CONTINUOUS=0, COUNT=1, input 0x1234 -> push 0x1234; valid stays 1 thereafter. Further input is not popped.
- rst asserted after 2 pops -> outputs return to reset values. The next 4 pops produce a result containing only post-reset data.

Source files
------------

// File: rtl/channel_reduce_param.sv
// channel_reduce_param: pops COUNT words from an input channel, folds them
// with a run-time selected operator (sum, max, min, xor) and pushes one
// result word to an output channel. Restarts after each result or halts,
// depending on CONTINUOUS.
module channel_reduce_param #(
  parameter int WIDTH      = 32,
  parameter int COUNT      = 4,
  parameter bit CONTINUOUS = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] in_in_data,
  output logic             in_read_valid,
  output logic             in_rst,
  output logic             in_write_valid,
  input  logic [WIDTH-1:0] in_out_data,
  input  logic             in_read_ready,
  input  logic             in_write_ready,
  output logic [WIDTH-1:0] out_in_data,
  output logic             out_read_valid,
  output logic             out_rst,
  output logic             out_write_valid,
  input  logic [WIDTH-1:0] out_out_data,
  input  logic             out_read_ready,
  input  logic             out_write_ready,
  output logic             valid,
  output logic             overflow
);

  localparam int CNT_W = $clog2(COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] ST_ACC   = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  localparam logic [1:0] OP_SUM = 2'd0;
  localparam logic [1:0] OP_MAX = 2'd1;
  localparam logic [1:0] OP_MIN = 2'd2;
  localparam logic [1:0] OP_XOR = 2'd3;

  logic [1:0]       state_r;
  logic [1:0]       state_nx_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] acc_r;
  logic [1:0]       op_r;
  logic             overflow_r;
  logic             valid_r;
  logic             pop_s;
  logic             push_s;
  logic [WIDTH:0]   fold_s;
  logic             unused_s;

  // Fold one element into the accumulator; MSB of the result is the sum carry.
  // Ties in max/min keep the accumulator.
  function automatic logic [WIDTH:0] fold(input logic [1:0] f_op,
                                          input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b);
    logic [WIDTH:0] r;
    case (f_op)
      OP_SUM:  r = {1'b0, a} + {1'b0, b};
      OP_MAX:  r = (b > a) ? {1'b0, b} : {1'b0, a};
      OP_MIN:  r = (b < a) ? {1'b0, b} : {1'b0, a};
      OP_XOR:  r = {1'b0, a ^ b};
      default: r = {1'b0, a};
    endcase
    return r;
  endfunction

  assign fold_s = fold(op_r, acc_r, in_out_data);

  // Handshake strobes and next-state selection; nothing moves while rst is high.
  always_comb begin
    pop_s      = 1'b0;
    push_s     = 1'b0;
    state_nx_s = state_r;
    case (state_r)
      ST_ACC: begin
        pop_s = in_read_ready & ~rst;
        if (pop_s && (cnt_r == CNT_LAST)) begin
          state_nx_s = ST_WRITE;
        end else begin
          state_nx_s = ST_ACC;
        end
      end
      ST_WRITE: begin
        push_s = out_write_ready & ~rst;
        if (push_s) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_WRITE;
        end
      end
      ST_DONE: begin
        if (CONTINUOUS) begin
          state_nx_s = ST_ACC;
        end else begin
          state_nx_s = ST_HALT;
        end
      end
      ST_HALT: begin
        state_nx_s = ST_HALT;
      end
      default: begin
        state_nx_s = ST_ACC;
      end
    endcase
  end

  // State, element counter, accumulator and sticky sum-overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_ACC;
      cnt_r      <= CNT_ZERO;
      acc_r      <= {WIDTH{1'b0}};
      op_r       <= OP_SUM;
      overflow_r <= 1'b0;
      valid_r    <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      valid_r <= (state_nx_s == ST_DONE) || (state_nx_s == ST_HALT);
      if (pop_s) begin
        cnt_r <= cnt_r + CNT_ONE;
        if (cnt_r == CNT_ZERO) begin
          // First element seeds the accumulator and latches the operator.
          acc_r      <= in_out_data;
          op_r       <= op;
          overflow_r <= 1'b0;
        end else begin
          acc_r      <= fold_s[WIDTH-1:0];
          overflow_r <= overflow_r | fold_s[WIDTH];
        end
      end else if (state_r == ST_DONE) begin
        cnt_r <= CNT_ZERO;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign in_read_valid   = pop_s;
  assign out_write_valid = push_s;
  assign out_in_data     = acc_r;
  assign valid           = valid_r;
  assign overflow        = overflow_r;

  assign in_in_data     = {WIDTH{1'b0}};
  assign in_rst         = 1'b0;
  assign in_write_valid = 1'b0;
  assign out_read_valid = 1'b0;
  assign out_rst        = 1'b0;

  assign unused_s = ^{in_write_ready, out_out_data, out_read_ready};

endmodule
